// File: rtl/store_monitor.sv
// -----------------------------------------------------------------------------
// store_monitor
//
// Watches the store bus of the multicycle ARM core and keeps a trace of every
// store in a small first-word-fall-through FIFO. It also decides the program
// verdict. A store to PASS_ADDR ends the run with PASS when the data matches
// PASS_DATA, and with FAIL otherwise. TIMEOUT is reached when no store to
// PASS_ADDR arrives within TIMEOUT cycles of reset release.
//
// Handshake: a store is offered when MemWrite is high for one cycle. The
// monitor has no backpressure, so every offered store in RUN is counted. The
// store is dropped (sticky overflow) only when the FIFO is full and no pop
// happens in the same cycle. The FIFO head is valid while empty is low, and
// rd_en consumes the head at the next rising edge. rd_en while empty does
// nothing.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   DataAdr    store address from the core
//   WriteData  store data from the core
//   MemWrite   store strobe, one cycle per store
//   rd_en      pop the FIFO head at the next edge
//   rd_adr     FIFO head address (0 while empty)
//   rd_data    FIFO head data (0 while empty)
//   empty      FIFO empty
//   full       FIFO full
//   count      FIFO occupancy
//   overflow   sticky flag: a store was dropped on a full FIFO
//   wr_count   stores seen in RUN, saturating at 16'hFFFF
//   done       verdict reached
//   pass       verdict is PASS
//   timeout    verdict is TIMEOUT
//   dbgState   raw FSM state (0 RUN, 1 PASS, 2 FAIL, 3 TOUT)
// -----------------------------------------------------------------------------
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADDR = 32'd100,
    parameter logic [31:0] PASS_DATA = 32'd7,
    parameter int          TIMEOUT   = 160
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    input  logic                       MemWrite,
    input  logic                       rd_en,
    output logic [31:0]                rd_adr,
    output logic [31:0]                rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                wr_count,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [1:0]                 dbgState
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] CYC_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TOUT = 2'd3
    } stateT;

    stateT          state;
    logic [TW-1:0]  cyc;
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [CW-1:0]  cnt;
    logic [31:0]    memAdr  [DEPTH];
    logic [31:0]    memData [DEPTH];

    logic isRun;
    logic isFull;
    logic isEmpty;
    logic pushReq;
    logic pushDo;
    logic popDo;
    logic passHit;

    assign isRun   = (state == ST_RUN);
    assign isFull  = (cnt == CNT_FULL);
    assign isEmpty = (cnt == '0);
    assign pushReq = MemWrite & isRun;
    assign popDo   = rd_en & ~isEmpty;
    // A simultaneous pop frees a slot, so a push on a full FIFO is not dropped.
    assign pushDo  = pushReq & (~isFull | popDo);
    assign passHit = MemWrite & (DataAdr == PASS_ADDR);

    // Verdict FSM. A store to PASS_ADDR takes priority over the timeout
    // in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            cyc   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (passHit) begin
                        state <= (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
                    end else if (cyc == CYC_LAST) begin
                        state <= ST_TOUT;
                    end else begin
                        cyc <= cyc + TW'(1);
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // FIFO control and store statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            wr_count <= '0;
        end else begin
            if (pushDo) wrPtr <= wrPtr + AW'(1);
            if (popDo)  rdPtr <= rdPtr + AW'(1);
            case ({pushDo, popDo})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (pushReq && isFull && !popDo) overflow <= 1'b1;
            if (pushReq && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end

    // The storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (pushDo) begin
            memAdr[wrPtr]  <= DataAdr;
            memData[wrPtr] <= WriteData;
        end
    end

    assign count    = cnt;
    assign empty    = isEmpty;
    assign full     = isFull;
    assign rd_adr   = isEmpty ? 32'd0 : memAdr[rdPtr];
    assign rd_data  = isEmpty ? 32'd0 : memData[rdPtr];
    assign done     = (state != ST_RUN);
    assign pass     = (state == ST_PASS);
    assign timeout  = (state == ST_TOUT);
    assign dbgState = state;

endmodule

// File: tb/tb_store_monitor.sv
// -----------------------------------------------------------------------------
// tb_store_monitor
//
// Directed bench for store_monitor. Stores accepted into the FIFO are pushed
// onto exp_q when they are driven. Each pop compares the FIFO head with the
// front of exp_q. Verdict, flags and counters are compared against constants
// derived from the store sequence.
// -----------------------------------------------------------------------------
module tb_store_monitor;

    localparam int          DEPTH     = 8;
    localparam logic [31:0] PASS_ADDR = 32'd100;

    logic        clk;
    logic        reset;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        rd_en;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] wr_count;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [1:0]  dbgState;

    logic [63:0] exp_q[$];
    bit          in_run;
    int          checks;
    int          errors;

    store_monitor #(
        .DEPTH(DEPTH), .PASS_ADDR(32'd100), .PASS_DATA(32'd7), .TIMEOUT(160)
    ) dut (
        .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .wr_count(wr_count), .done(done), .pass(pass), .timeout(timeout),
        .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One clock cycle: drive the inputs, compare the head when popping, take
    // the edge, update the scoreboard, and return #1 after the edge.
    task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d, input bit re);
        bit pop_ok;
        pop_ok = re && (exp_q.size() > 0);
        if (pop_ok) check("pop_head", {rd_adr, rd_data}, exp_q[0]);
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        rd_en     = re;
        @(posedge clk);
        if (pop_ok) void'(exp_q.pop_front());
        if (we && in_run) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
            if (a == PASS_ADDR) in_run = 1'b0;
        end
        #1;
        MemWrite = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Pulse reset between edges; the monitor restarts from RUN.
    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        in_run = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Pop everything expected, bounded by the FIFO depth.
    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) tick(1'b0, 32'd0, 32'd0, 1'b1);
        check({tag, "_drained_q"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_drained_empty"}, 64'(empty), 64'd1);
        check({tag, "_drained_count"}, 64'(count), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        checks    = 0;
        errors    = 0;
        in_run    = 1'b1;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        rd_en     = 1'b0;

        // Reset values
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_flags", {61'd0, done, pass, timeout}, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_head", {rd_adr, rd_data}, 64'd0);
        check("rst_state", 64'(dbgState), 64'd0);
        #21;
        reset = 1'b0;

        // 1: three trace stores, no pop. 0x64 equals PASS_ADDR (100), so the
        // middle store uses 0x6C to keep the run going.
        tick(1'b1, 32'h60, 32'h11, 1'b0);
        check("t1_fwft_head", {rd_adr, rd_data}, {32'h60, 32'h11});
        tick(1'b1, 32'h6C, 32'h22, 1'b0);
        tick(1'b1, 32'h68, 32'h33, 1'b0);
        check("t1_count", 64'(count), 64'd3);
        check("t1_wr_count", 64'(wr_count), 64'd3);
        check("t1_head", {rd_adr, rd_data}, {32'h60, 32'h11});
        check("t1_done", 64'(done), 64'd0);
        drain("t1");

        // 2: PASS verdict; later stores are ignored
        do_reset();
        tick(1'b1, 32'h6C, 32'd7, 1'b0);
        tick(1'b1, 32'd100, 32'd7, 1'b0);
        check("t2_pass", {61'd0, done, pass, timeout}, {61'd0, 3'b110});
        check("t2_count", 64'(count), 64'd2);
        tick(1'b1, 32'h70, 32'd5, 1'b0);
        check("t2_wr_count_frozen", 64'(wr_count), 64'd2);
        check("t2_count_frozen", 64'(count), 64'd2);
        drain("t2");
        check("t2_pass_after_drain", 64'(pass), 64'd1);

        // 3: FAIL verdict
        do_reset();
        tick(1'b1, 32'd100, 32'd8, 1'b0);
        check("t3_fail", {61'd0, done, pass, timeout}, {61'd0, 3'b100});
        check("t3_state", 64'(dbgState), 64'd2);
        drain("t3");

        // 4a: timeout lands on edge 160 after reset release
        do_reset();
        idle(159);
        check("t4_no_timeout_159", 64'(timeout), 64'd0);
        idle(1);
        check("t4_timeout_160", {61'd0, done, pass, timeout}, {61'd0, 3'b101});
        // 4b: a PASS store on the last cycle beats the timeout
        do_reset();
        idle(159);
        tick(1'b1, 32'd100, 32'd7, 1'b0);
        check("t4_pass_wins", {61'd0, done, pass, timeout}, {61'd0, 3'b110});
        drain("t4");

        // 5: overflow on the ninth store, then push+pop while full
        do_reset();
        for (int i = 0; i < 9; i++) begin
            d = 32'($urandom_range(0, 16'hFFFF));
            tick(1'b1, 32'h200 + 32'(4 * i), d, 1'b0);
        end
        check("t5_full", 64'(full), 64'd1);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_count", 64'(count), 64'd8);
        check("t5_wr_count", 64'(wr_count), 64'd9);
        tick(1'b1, 32'h300, 32'hBEEF, 1'b1);
        check("t5_pushpop_count", 64'(count), 64'd8);
        check("t5_pushpop_wr_count", 64'(wr_count), 64'd10);
        drain("t5");
        check("t5_overflow_sticky", 64'(overflow), 64'd1);

        // 6: asynchronous reset mid-run, then pops on an empty FIFO
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = 32'($urandom_range(0, 16'hFFFF));
            tick(1'b1, 32'h400 + 32'(4 * i), d, 1'b0);
        end
        idle(35);
        check("t6_pre_count", 64'(count), 64'd5);
        reset = 1'b1;
        #1;
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_empty", 64'(empty), 64'd1);
        check("t6_async_wr_count", 64'(wr_count), 64'd0);
        check("t6_async_head", {rd_adr, rd_data}, 64'd0);
        check("t6_async_flags", {61'd0, done, pass, timeout}, 64'd0);
        exp_q.delete();
        in_run = 1'b1;
        #1;
        reset = 1'b0;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        check("t6_pop_empty_count", 64'(count), 64'd0);
        check("t6_pop_empty_empty", 64'(empty), 64'd1);
        tick(1'b1, 32'h500, 32'hAB, 1'b1);
        check("t6_pushpop_empty_count", 64'(count), 64'd1);
        check("t6_pushpop_empty_head", {rd_adr, rd_data}, {32'h500, 32'hAB});
        // The cycle counter restarted at reset: two ticks so far.
        idle(157);
        check("t6_cyc_cleared", 64'(timeout), 64'd0);
        idle(1);
        check("t6_timeout", 64'(timeout), 64'd1);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
